// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared button FSM states and ms-to-cycles helper
package button_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } btn_state_e;

  // 64-bit arithmetic so large clock rates times long hold times cannot overflow
  function automatic longint unsigned ms_to_cycles(input longint unsigned freq,
                                                   input longint unsigned ms);
    return (freq * ms) / 64'd1000;
  endfunction

endpackage

// File: rtl/button_event_decoder.sv
// rtl/button_event_decoder.sv - turns a debounced button level into press/release/click/long/repeat strobes
module button_event_decoder
  import button_pkg::*;
#(
  parameter int WIDTH_COUNTER = 24,
  parameter int CLOCK_FREQ    = 10_000_000,
  parameter int LONG_PRESS_MS = 1000,
  parameter int REPEAT_MS     = 200
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic debounced_i,
  input  logic enable_i,
  output logic press_o,
  output logic release_o,
  output logic click_o,
  output logic long_press_o,
  output logic repeat_o,
  output logic held_o
);

  localparam longint unsigned LONG_CYCLES   = ms_to_cycles(64'(CLOCK_FREQ), 64'(LONG_PRESS_MS));
  localparam longint unsigned REPEAT_CYCLES = ms_to_cycles(64'(CLOCK_FREQ), 64'(REPEAT_MS));
  localparam longint unsigned COUNT_MAX     = (64'd1 << WIDTH_COUNTER) - 64'd1;
  localparam logic            REPEAT_EN     = (REPEAT_CYCLES != 64'd0);

  localparam logic [WIDTH_COUNTER-1:0] LONG_LAST   = WIDTH_COUNTER'(LONG_CYCLES - 64'd1);
  localparam logic [WIDTH_COUNTER-1:0] REPEAT_LAST =
    REPEAT_EN ? WIDTH_COUNTER'(REPEAT_CYCLES - 64'd1) : '0;

  // Thresholds must be reachable by the counter, otherwise a match would never occur
  if (LONG_CYCLES == 64'd0 || LONG_CYCLES > COUNT_MAX || REPEAT_CYCLES > COUNT_MAX) begin : g_bad_width
    $error("button_event_decoder: WIDTH_COUNTER too small for LONG/REPEAT cycle counts");
  end

  btn_state_e               state_q, state_d;
  logic [WIDTH_COUNTER-1:0] cnt_q, cnt_d, cnt_inc;
  logic                     d_q;
  logic                     rise, fall;
  logic                     press_q, release_q, click_q, long_q, repeat_q;
  logic                     press_d, release_d, click_d, long_d, repeat_d;

  assign rise = debounced_i & ~d_q;
  assign fall = ~debounced_i & d_q;

  // Previous input level, tracked even while disabled so re-enable mid-hold is not a press
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) d_q <= 1'b0;
    else           d_q <= debounced_i;
  end

  // Next state, next counter and strobe decode; release takes priority over thresholds
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + WIDTH_COUNTER'(1);
    press_d   = 1'b0;
    release_d = 1'b0;
    click_d   = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    if (!enable_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            press_d = 1'b1;
            state_d = PRESSED;
          end
        end
        PRESSED: begin
          if (fall) begin
            release_d = 1'b1;
            click_d   = 1'b1;
            state_d   = IDLE;
          end else if (cnt_q == LONG_LAST) begin
            long_d  = 1'b1;
            state_d = HELD;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        HELD: begin
          if (fall) begin
            release_d = 1'b1;
            state_d   = IDLE;
          end else if (REPEAT_EN && cnt_q == REPEAT_LAST) begin
            repeat_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state and registered one-shot strobes
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= IDLE;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
      click_q   <= click_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
    end
  end

  // Hold-time counter; saturates so an endless hold without repeat cannot wrap
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end

  assign press_o      = press_q;
  assign release_o    = release_q;
  assign click_o      = click_q;
  assign long_press_o = long_q;
  assign repeat_o     = repeat_q;
  assign held_o       = (state_q != IDLE);

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Consumes the debounced switch/button level from the input-conditioning stage.
- Converts that level into single-cycle user events: press, release, short click, long press and auto-repeat while held.
- Sits between the debouncer and application control logic (mode/counter FSMs), so downstream logic sees clean one-shot strobes instead of levels.
- Fully synchronous to clk_i; the input is already synchronised upstream.

Parameters:
- WIDTH_COUNTER, 24, width of the hold-time counter; must hold LONG_CYCLES and REPEAT_CYCLES (elaboration-time assertion).
- CLOCK_FREQ, 10_000_000, clk_i frequency in Hz.
- LONG_PRESS_MS, 1000, hold time before long_press_o fires.
- REPEAT_MS, 200, auto-repeat period after the long press; 0 disables repeat.

Ports:
- clk_i  input  1  system clock.
- reset_ni  input  1  asynchronous, active-low reset.
- debounced_i  input  1  debounced button level (1 = pressed), synchronous to clk_i.
- enable_i  input  1  event generation enable.
- press_o  output  1  1-cycle strobe on press.
- release_o  output  1  1-cycle strobe on every release.
- click_o  output  1  1-cycle strobe on release before the long-press threshold.
- long_press_o  output  1  1-cycle strobe when the hold reaches LONG_PRESS_MS.
- repeat_o  output  1  1-cycle strobe every REPEAT_MS after the long press.
- held_o  output  1  level; high while the FSM is not in IDLE.

Behaviour:
- Clock and reset: clk_i is the clock; reset_ni is an asynchronous, active-low reset.
- Reset values: state IDLE, counter 0, prev-level register d_q 0. All outputs 0.
- Derived constants: LONG_CYCLES = CLOCK_FREQ*LONG_PRESS_MS/1000 and REPEAT_CYCLES = CLOCK_FREQ*REPEAT_MS/1000, both computed in integer arithmetic.
- Edge detection:
  - d_q <= debounced_i every cycle, regardless of enable_i.
  - rise = debounced_i & ~d_q; fall = ~debounced_i & d_q.
- Outputs: all are registered. Each strobe is high for exactly one cycle, asserted on the clock edge after the cycle in which its condition is true (latency 1).
- IDLE:
  - Counter held at 0.
  - On rise with enable_i=1: press_o, go to PRESSED, counter 0.
- PRESSED:
  - Counter increments each cycle.
  - On fall: release_o and click_o, go to IDLE.
  - Else when counter == LONG_CYCLES-1: long_press_o, go to HELD, counter 0.
- HELD:
  - Counter increments each cycle.
  - On fall: release_o only (no click_o), go to IDLE.
  - Else if REPEAT_CYCLES != 0 and counter == REPEAT_CYCLES-1: repeat_o, counter 0.
- Simultaneous events: fall on the same cycle as a threshold match means release wins. No long_press_o or repeat_o is issued, and counter is cleared.
- enable_i=0: the FSM is forced to IDLE and counter to 0 next cycle. No strobes are produced and held_o goes 0. A pending release produces no strobe.
- Re-enable while the button is held: no press_o, because d_q already equals 1. A new press requires a release and then a press.
- Pressed at reset exit: d_q resets to 0, so debounced_i=1 directly after reset produces press_o.
- Counter: never wraps, because the thresholds are bounded by the width assertion. It must not overflow in HELD with repeat disabled; it saturates at its maximum value.
- Reset mid-hold: immediate return to IDLE with all outputs 0.
- Mutual exclusion: press_o, release_o, long_press_o and repeat_o are never high in the same cycle.

Decomposition:
- Package button_pkg holds:
  - typedef enum logic [1:0] btn_state_e {IDLE, PRESSED, HELD};
  - function ms_to_cycles(freq, ms), shared with the debouncer's stable-time computation.
- No sub-module: the edge detect is two gates plus one flop and stays inline. FSM and counter sit in separate always_ff blocks.

Test Plan:
Bench parameters: CLOCK_FREQ=1000 (1 cycle/ms), LONG_PRESS_MS=10, REPEAT_MS=4.
- Short click: drive debounced_i=1 for 5 cycles, then 0. Expect press_o one cycle after the rise; release_o and click_o one cycle after the fall; no long_press_o.
- Long hold with repeat: hold 1 for 30 cycles. Expect:
  - long_press_o 10 cycles after press_o;
  - repeat_o every 4 cycles after that (4 pulses before the release at cycle 30);
  - release_o on release, click_o=0.
- Boundary: release on exactly the cycle the counter hits 9. Expect release_o and click_o; long_press_o never asserted.
- Repeat disabled: REPEAT_MS=0, hold 50 cycles. Expect exactly one long_press_o and zero repeat_o; held_o=1 until release.
- Enable gating: press with enable_i=0, raise enable_i mid-hold, then release and press again. Expect no strobes until the second press, which produces press_o.
- Reset mid-hold: assert reset_ni=0 in the HELD state. Expect all outputs 0 immediately and held_o=0. After reset release with debounced_i=1, expect press_o.
